// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite channel bundle between a master (xbar mst port) and axi_lite_mem_slave.
interface axi_lite_mem_slave_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64
);
    localparam int unsigned StrbW = DataWidth / 8;

    logic [AddrWidth-1:0] aw_addr;
    logic [2:0]           aw_prot;
    logic                 aw_valid;
    logic                 aw_ready;

    logic [DataWidth-1:0] w_data;
    logic [StrbW-1:0]     w_strb;
    logic                 w_valid;
    logic                 w_ready;

    logic [1:0]           b_resp;
    logic                 b_valid;
    logic                 b_ready;

    logic [AddrWidth-1:0] ar_addr;
    logic [2:0]           ar_prot;
    logic                 ar_valid;
    logic                 ar_ready;

    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;
    logic                 r_valid;
    logic                 r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory slave backed by a flop array; out-of-range accesses get SLVERR.
// Optional build macro AXI_LITE_MEM_SLAVE_PROT_CHECK_EN: unprivileged accesses
// (prot[0]==0) are refused with SLVERR (writes commit nothing, reads return 0).
module axi_lite_mem_slave #(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          NumWords  = 512,
    parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(32'h0000_3000)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_lite_mem_slave_if.slave  bus,
    output logic                 busy
);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = $clog2(NumWords);
    localparam logic [AddrWidth:0] EndAddr =
        (AddrWidth+1)'(BaseAddr) + (AddrWidth+1)'(NumWords * StrbW);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;

    // Address decode helpers; comparison is one bit wider so the end bound never wraps.
    function automatic logic in_range(input logic [AddrWidth-1:0] addr);
        return ({1'b0, addr} >= {1'b0, BaseAddr}) && ({1'b0, addr} < EndAddr);
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] off;
        off = addr - BaseAddr;
        return IdxW'(off >> OffW);
    endfunction

    logic [DataWidth-1:0] mem [NumWords];

    w_state_e             w_state_q, w_state_d;
    logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
    logic [2:0]           aw_prot_q, aw_prot_d;
    logic [DataWidth-1:0] w_data_q, w_data_d;
    logic [StrbW-1:0]     w_strb_q, w_strb_d;
    logic [1:0]           b_resp_q, b_resp_d;
    logic                 b_valid_q, aw_ready_q, w_ready_q;

    logic                 r_valid_q, r_valid_d;
    logic [DataWidth-1:0] r_data_q, r_data_d;
    logic [1:0]           r_resp_q, r_resp_d;
    logic                 busy_q, rst_done_q;

    logic                 aw_hs_c, w_hs_c, ar_hs_c, ar_ready_c;
    logic                 commit_c, wr_ok_c, wr_en_c, rd_ok_c;
    logic [AddrWidth-1:0] cm_addr_c;
    logic [2:0]           cm_prot_c;
    logic [DataWidth-1:0] cm_data_c, wr_word_c;
    logic [StrbW-1:0]     cm_strb_c;
    logic [IdxW-1:0]      wr_idx_c, rd_idx_c;

    logic unused_prot;
    assign unused_prot = ^{bus.aw_prot, bus.ar_prot, cm_prot_c};

    assign aw_hs_c    = bus.aw_valid && aw_ready_q;
    assign w_hs_c     = bus.w_valid && w_ready_q;
    // ar_ready only looks at r_ready and internal state, never at a valid.
    assign ar_ready_c = rst_done_q && (!r_valid_q || bus.r_ready);
    assign ar_hs_c    = bus.ar_valid && ar_ready_c;

    // Write FSM next state, payload capture and commit word merge.
    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        aw_prot_d = aw_prot_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_resp_d  = b_resp_q;
        commit_c  = 1'b0;
        cm_addr_c = bus.aw_addr;
        cm_prot_c = bus.aw_prot;
        cm_data_c = bus.w_data;
        cm_strb_c = bus.w_strb;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c = 1'b1;
                end else if (aw_hs_c) begin
                    aw_addr_d = bus.aw_addr;
                    aw_prot_d = bus.aw_prot;
                    w_state_d = W_HAVE_AW;
                end else if (w_hs_c) begin
                    w_data_d  = bus.w_data;
                    w_strb_d  = bus.w_strb;
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                cm_addr_c = aw_addr_q;
                cm_prot_c = aw_prot_q;
                commit_c  = w_hs_c;
            end
            W_HAVE_W: begin
                cm_data_c = w_data_q;
                cm_strb_c = w_strb_q;
                commit_c  = aw_hs_c;
            end
            W_RESP: begin
                if (bus.b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

`ifdef AXI_LITE_MEM_SLAVE_PROT_CHECK_EN
        wr_ok_c = in_range(cm_addr_c) && cm_prot_c[0];
`else
        wr_ok_c = in_range(cm_addr_c);
`endif
        if (commit_c) begin
            w_state_d = W_RESP;
            b_resp_d  = wr_ok_c ? RespOkay : RespSlverr;
        end
        wr_en_c   = commit_c && wr_ok_c;
        wr_idx_c  = word_idx(cm_addr_c);
        wr_word_c = mem[wr_idx_c];
        for (int unsigned b = 0; b < StrbW; b++) begin
            if (cm_strb_c[b]) begin
                wr_word_c[b*8 +: 8] = cm_data_c[b*8 +: 8];
            end
        end
    end

    // Read output register; a same-cycle write to the same word is forwarded.
    always_comb begin
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        rd_idx_c  = word_idx(bus.ar_addr);
`ifdef AXI_LITE_MEM_SLAVE_PROT_CHECK_EN
        rd_ok_c   = in_range(bus.ar_addr) && bus.ar_prot[0];
`else
        rd_ok_c   = in_range(bus.ar_addr);
`endif
        if (ar_hs_c) begin
            r_valid_d = 1'b1;
            r_resp_d  = rd_ok_c ? RespOkay : RespSlverr;
            r_data_d  = '0;
            if (rd_ok_c) begin
                r_data_d = (wr_en_c && (wr_idx_c == rd_idx_c)) ? wr_word_c : mem[rd_idx_c];
            end
        end else if (bus.r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    // Control and payload registers for both channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            aw_prot_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_resp_q   <= RespOkay;
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RespOkay;
            busy_q     <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_prot_q  <= aw_prot_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_resp_q   <= b_resp_d;
            b_valid_q  <= (w_state_d == W_RESP);
            aw_ready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
            w_ready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            busy_q     <= (w_state_d != W_IDLE) || r_valid_d;
            rst_done_q <= 1'b1;
        end
    end

    // Storage array; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumWords; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem[wr_idx_c] <= wr_word_c;
        end
    end

    assign bus.aw_ready = aw_ready_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;
    assign bus.ar_ready = ar_ready_c;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomized bench for axi_lite_mem_slave against a byte-level reference memory.
module tb_axi_lite_mem_slave;
    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam logic [31:0] LAST   = 32'h0000_3FFF;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic clk;
    logic rst_n;
    logic busy;

    axi_lite_mem_slave_if #(.AddrWidth(32), .DataWidth(64)) bus ();

    axi_lite_mem_slave #(
        .AddrWidth(32), .DataWidth(64), .NumWords(512), .BaseAddr(32'h0000_3000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] mdl [512];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_in(input logic [31:0] a);
        return (a >= BASE) && (a <= LAST);
    endfunction

    function automatic bit ref_ok(input logic [31:0] a, input logic [2:0] prot);
`ifdef AXI_LITE_MEM_SLAVE_PROT_CHECK_EN
        return ref_in(a) && prot[0];
`else
        return ref_in(a) && (prot == prot);
`endif
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a - BASE) / 8);
    endfunction

    function automatic logic [31:0] pick_addr();
        int k;
        k = $urandom_range(0, 11);
        case (k)
            0: return 32'h0000_2FF8;
            1: return 32'h0000_4000 + 32'($urandom_range(0, 7));
            2: return 32'h0000_3FF8 + 32'($urandom_range(0, 7));
            3: return $urandom;
            default: return BASE + 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input logic [2:0] prot, input int aw_dly, input int w_dly, input int b_hold);
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; cyc = 0;
        exp_resp = ref_ok(addr, prot) ? OKAY : SLVERR;
        bus.aw_addr = addr; bus.aw_prot = prot;
        bus.w_data  = data; bus.w_strb  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.aw_valid = !aw_done && (cyc >= aw_dly);
            bus.w_valid  = !w_done && (cyc >= w_dly);
            if (w_done && !aw_done) begin
                check_val("have_w_aw_ready", 64'(bus.aw_ready), 1);
                check_val("have_w_w_ready", 64'(bus.w_ready), 0);
            end
            if (aw_done && !w_done) begin
                check_val("have_aw_aw_ready", 64'(bus.aw_ready), 0);
                check_val("have_aw_w_ready", 64'(bus.w_ready), 1);
            end
            hs_aw = bus.aw_valid && bus.aw_ready;
            hs_w  = bus.w_valid && bus.w_ready;
            tick();
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
        end
        bus.aw_valid = 0; bus.w_valid = 0;
        check_val("write_handshakes", 64'(aw_done && w_done), 1);
        check_val("b_valid_latency", 64'(bus.b_valid), 1);
        check_val("b_resp", 64'(bus.b_resp), 64'(exp_resp));
        check_val("busy_write", 64'(busy), 1);
        if (exp_resp == OKAY) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) mdl[ref_idx(addr)][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        for (int i = 0; i < b_hold; i++) begin
            tick();
            check_val("b_hold_valid", 64'(bus.b_valid), 1);
            check_val("b_hold_resp", 64'(bus.b_resp), 64'(exp_resp));
            check_val("b_hold_aw_ready", 64'(bus.aw_ready), 0);
            check_val("b_hold_w_ready", 64'(bus.w_ready), 0);
        end
        bus.b_ready = 1;
        tick();
        bus.b_ready = 0;
        check_val("b_done_valid", 64'(bus.b_valid), 0);
        check_val("b_done_aw_ready", 64'(bus.aw_ready), 1);
        check_val("b_done_w_ready", 64'(bus.w_ready), 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot, output logic [63:0] got);
        bit hs;
        int cyc;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        hs = 0; cyc = 0;
        exp_resp = ref_ok(addr, prot) ? OKAY : SLVERR;
        exp_data = (exp_resp == OKAY) ? mdl[ref_idx(addr)] : 64'h0;
        bus.ar_addr = addr; bus.ar_prot = prot; bus.r_ready = 0;
        bus.ar_valid = 1;
        while (!hs && cyc < 20) begin
            hs = bus.ar_ready;
            tick();
            cyc++;
        end
        bus.ar_valid = 0;
        check_val("ar_handshake", 64'(hs), 1);
        check_val("r_valid", 64'(bus.r_valid), 1);
        check_val("r_data", bus.r_data, exp_data);
        check_val("r_resp", 64'(bus.r_resp), 64'(exp_resp));
        check_val("busy_read", 64'(busy), 1);
        got = bus.r_data;
        bus.r_ready = 1;
        tick();
        bus.r_ready = 0;
        check_val("r_done_valid", 64'(bus.r_valid), 0);
    endtask

    // Back-to-back reads with r_ready alternating; results matched in order from a queue.
    task automatic stream_reads(input int n);
        logic [63:0] exp_q[$];
        logic [1:0]  rsp_q[$];
        logic [63:0] held;
        bit held_v, hs_ar, hs_r;
        int issued, got, cyc;
        logic [31:0] a;
        issued = 0; got = 0; cyc = 0; held_v = 0; held = '0;
        a = pick_addr();
        bus.ar_prot = 3'b001;
        while (got < n && cyc < n * 4 + 20) begin
            if (held_v) check_val("r_stable", bus.r_data, held);
            bus.r_ready  = (cyc % 2 == 0);
            bus.ar_valid = (issued < n);
            bus.ar_addr  = a;
            #1;
            hs_ar = bus.ar_valid && bus.ar_ready;
            hs_r  = bus.r_valid && bus.r_ready;
            if (hs_r) begin
                if (exp_q.size() > 0) begin
                    check_val("stream_data", bus.r_data, exp_q.pop_front());
                    check_val("stream_resp", 64'(bus.r_resp), 64'(rsp_q.pop_front()));
                end else begin
                    check_val("stream_extra_beat", 64'(1), 64'(0));
                end
                got++;
            end
            held_v = bus.r_valid && !bus.r_ready;
            held   = bus.r_data;
            if (hs_ar) begin
                exp_q.push_back(ref_in(a) ? mdl[ref_idx(a)] : 64'h0);
                rsp_q.push_back(ref_in(a) ? OKAY : SLVERR);
                issued++;
                a = pick_addr();
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.ar_valid = 0; bus.r_ready = 0;
        check_val("stream_beats", 64'(got), 64'(n));
        check_val("stream_left", 64'(exp_q.size()), 0);
    endtask

    logic [63:0] rd;

    initial begin
        for (int i = 0; i < 512; i++) mdl[i] = '0;
        rst_n = 0;
        bus.aw_addr = '0; bus.aw_prot = '0; bus.aw_valid = 0;
        bus.w_data = '0;  bus.w_strb = '0;  bus.w_valid = 0;
        bus.b_ready = 0;
        bus.ar_addr = '0; bus.ar_prot = '0; bus.ar_valid = 0;
        bus.r_ready = 0;
        repeat (3) tick();
        check_val("rst_b_valid", 64'(bus.b_valid), 0);
        check_val("rst_r_valid", 64'(bus.r_valid), 0);
        check_val("rst_aw_ready", 64'(bus.aw_ready), 0);
        check_val("rst_ar_ready", 64'(bus.ar_ready), 0);
        check_val("rst_busy", 64'(busy), 0);
        rst_n = 1;
        tick();
        check_val("idle_aw_ready", 64'(bus.aw_ready), 1);
        check_val("idle_w_ready", 64'(bus.w_ready), 1);
        check_val("idle_ar_ready", 64'(bus.ar_ready), 1);
        check_val("idle_busy", 64'(busy), 0);

        // Same-cycle AW+W, then read back.
        axi_write(32'h3010, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 3'b001, 0, 0, 0);
        axi_read(32'h3010, 3'b001, rd);
        check_val("full_word", rd, 64'hDEAD_BEEF_DEAD_BEEF);

        // W three cycles ahead of AW, low four bytes only.
        axi_write(32'h3018, 64'hDEAD_BEEF_DEAD_BEEF, 8'h0F, 3'b001, 3, 0, 0);
        axi_read(32'h3018, 3'b001, rd);
        check_val("byte_merge", rd, 64'h0000_0000_DEAD_BEEF);

        // AW ahead of W and a zero-strobe write.
        axi_write(32'h3020, 64'h1122_3344_5566_7788, 8'hA5, 3'b001, 0, 2, 0);
        axi_write(32'h3020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3'b001, 0, 0, 0);
        axi_read(32'h3020, 3'b001, rd);
        check_val("strb_a5", rd, 64'h1100_3300_0066_0088);

        // Out-of-range edges.
        axi_write(32'h4000, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 3'b001, 0, 0, 0);
        axi_read(32'h2FF8, 3'b001, rd);
        axi_read(32'h4000, 3'b001, rd);
        axi_read(32'h3FF8, 3'b001, rd);
        check_val("last_word_untouched", rd, 64'h0);

        // B stalled for five cycles.
        axi_write(32'h3028, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'b001, 0, 0, 5);

        // Privilege bit.
        axi_write(32'h3030, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 3'b000, 0, 0, 0);
        axi_read(32'h3030, 3'b001, rd);
        axi_write(32'h3038, 64'h5555_6666_7777_8888, 8'hFF, 3'b001, 0, 0, 0);
        axi_read(32'h3038, 3'b000, rd);

        // Same-cycle write commit and read of the same word sees new data.
        check_val("wf_aw_ready", 64'(bus.aw_ready), 1);
        check_val("wf_ar_ready", 64'(bus.ar_ready), 1);
        bus.aw_addr = 32'h3010; bus.aw_prot = 3'b001; bus.aw_valid = 1;
        bus.w_data = 64'h0F0F_0F0F_0F0F_0F0F; bus.w_strb = 8'hF0; bus.w_valid = 1;
        bus.ar_addr = 32'h3010; bus.ar_prot = 3'b001; bus.ar_valid = 1;
        tick();
        bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0;
        mdl[2] = 64'h0F0F_0F0F_DEAD_BEEF;
        check_val("wf_b_valid", 64'(bus.b_valid), 1);
        check_val("wf_r_valid", 64'(bus.r_valid), 1);
        check_val("wf_r_data", bus.r_data, 64'h0F0F_0F0F_DEAD_BEEF);
        bus.b_ready = 1; bus.r_ready = 1;
        tick();
        bus.b_ready = 0; bus.r_ready = 0;
        check_val("wf_done_busy", 64'(busy), 0);

        stream_reads(24);

        // Random mix of writes and reads.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                axi_write(pick_addr(), {$urandom, $urandom}, 8'($urandom), 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                axi_read(pick_addr(), 3'($urandom_range(0, 7)), rd);
            end
        end
        stream_reads(16);

        // Reset with a write half-accepted: nothing comes back, memory cleared.
        bus.aw_addr = 32'h3010; bus.aw_prot = 3'b001; bus.aw_valid = 1;
        tick();
        bus.aw_valid = 0;
        check_val("mid_have_aw_busy", 64'(busy), 1);
        rst_n = 0;
        #1;
        check_val("mid_rst_busy", 64'(busy), 0);
        check_val("mid_rst_b_valid", 64'(bus.b_valid), 0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 512; i++) mdl[i] = '0;
        tick();
        check_val("post_rst_b_valid", 64'(bus.b_valid), 0);
        check_val("post_rst_aw_ready", 64'(bus.aw_ready), 1);
        check_val("post_rst_w_ready", 64'(bus.w_ready), 1);
        axi_read(32'h3010, 3'b001, rd);
        check_val("post_rst_cleared", rd, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
